// File: rtl/vc_buffer_pkt.sv
// vc_buffer_pkt: single-VC input buffer for a router input port.
// First-word-fall-through flit FIFO storing each flit with its VC id. A packet
// lock FSM enforces head/body/tail framing, drops out-of-order flits and raises
// a sticky error flag. Occupancy and almost-full are exported for credit logic.
module vc_buffer_pkt #(
  parameter int FLIT_WIDTH  = 34,
  parameter int DEPTH       = 4,
  parameter int VC_ID_WIDTH = 2,
  parameter int AFULL_THR   = 3
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [VC_ID_WIDTH-1:0]   vc_id_i,
  input  logic [FLIT_WIDTH-1:0]    fdata_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [FLIT_WIDTH-1:0]    fdata_o,
  output logic [VC_ID_WIDTH-1:0]   vc_id_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   ocup_o,
  output logic                     almost_full_o,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = FLIT_WIDTH + VC_ID_WIDTH;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THR);

  localparam logic [1:0] T_HEAD   = 2'b00;
  localparam logic [1:0] T_BODY   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {UNLOCKED, LOCKED} lock_t;

  // Entry layout: {vc_id, flit}
  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  lock_t         lock_reg, lock_next;
  logic          err_reg, err_next;

  logic          empty, full;
  logic          xin, xout, store;
  logic [1:0]    ftype;
  logic [EW-1:0] head_entry;

  // Pointer-derived status; the extra MSB distinguishes full from empty
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // ready depends on state only: a read while full does not reopen it this cycle
  assign ready_o = !full;
  assign valid_o = !empty;
  assign xin     = valid_i & ready_o;
  assign xout    = valid_o & ready_i;

  assign ftype = fdata_i[FLIT_WIDTH-1 -: 2];

  // Lock FSM next state: decide whether an accepted flit is stored or dropped
  always_comb begin
    lock_next = lock_reg;
    err_next  = err_reg;
    store     = 1'b0;
    if (xin) begin
      case (lock_reg)
        UNLOCKED: begin
          case (ftype)
            T_HEAD: begin
              store     = 1'b1;
              lock_next = LOCKED;
            end
            T_SINGLE: store = 1'b1;
            default:  err_next = 1'b1;
          endcase
        end
        LOCKED: begin
          case (ftype)
            T_BODY: store = 1'b1;
            T_TAIL: begin
              store     = 1'b1;
              lock_next = UNLOCKED;
            end
            default: err_next = 1'b1;
          endcase
        end
        default: lock_next = UNLOCKED;
      endcase
    end
  end

  // State register: pointers, lock state and sticky error; reset wins over traffic
  always_ff @(posedge clk) begin
    if (arst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      lock_reg   <= UNLOCKED;
      err_reg    <= 1'b0;
    end else begin
      lock_reg <= lock_next;
      err_reg  <= err_next;
      if (store) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (xout)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since pointers qualify them
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr_reg[AW-1:0]] <= {vc_id_i, fdata_i};
  end

  // Head of queue is read combinationally for fall-through, forced to 0 when empty
  assign head_entry    = mem[rd_ptr_reg[AW-1:0]];
  assign fdata_o       = empty ? '0 : head_entry[FLIT_WIDTH-1:0];
  assign vc_id_o       = empty ? '0 : head_entry[EW-1:FLIT_WIDTH];
  assign ocup_o        = wr_ptr_reg - rd_ptr_reg;
  assign almost_full_o = (ocup_o >= AFULL_LVL);
  assign err_o         = err_reg;

endmodule

// File: tb/tb_vc_buffer_pkt.sv
// tb_vc_buffer_pkt: scoreboard bench for vc_buffer_pkt (DEPTH=4, AFULL_THR=3).
// Stimulus pushes expected {vc_id, flit} for every flit that should be stored;
// a negedge monitor pops and compares whenever the DUT hands out a flit.
module tb_vc_buffer_pkt;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [1:0]  vc_id_i = '0;
  logic [33:0] fdata_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [33:0] fdata_o;
  logic [1:0]  vc_id_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [2:0]  ocup_o;
  logic        almost_full_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] exp_q [$];

  vc_buffer_pkt #(
    .FLIT_WIDTH(34), .DEPTH(4), .VC_ID_WIDTH(2), .AFULL_THR(3)
  ) dut (
    .clk(clk), .arst(arst), .vc_id_i(vc_id_i), .fdata_i(fdata_i),
    .valid_i(valid_i), .ready_o(ready_o), .fdata_o(fdata_o),
    .vc_id_o(vc_id_o), .valid_o(valid_o), .ready_i(ready_i),
    .ocup_o(ocup_o), .almost_full_o(almost_full_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  // Monitor: one line per flit leaving the buffer
  always @(negedge clk) begin
    if (!arst && valid_o && ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL out_unexpected: got vc=%0d flit=0x%0h expected none", vc_id_o, fdata_o);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({vc_id_o, fdata_o} !== e) begin
          n_bad++;
          $display("FAIL out_flit: got vc=%0d flit=0x%0h expected vc=%0d flit=0x%0h",
                   vc_id_o, fdata_o, e[35:34], e[33:0]);
        end else begin
          $display("out  vc=%0d flit=0x%0h", vc_id_o, fdata_o);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    ready_i = 1'b0;
    valid_i = 1'b0;
    arst    = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    arst = 1'b0;
    exp_q.delete();
  endtask

  // Present one flit for exactly one cycle (caller knows ready_o is high)
  task automatic put(input logic [1:0] vc, input logic [33:0] d, input bit exp_store);
    vc_id_i = vc;
    fdata_i = d;
    valid_i = 1'b1;
    if (exp_store) exp_q.push_back({vc, d});
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_valid_o", 64'(valid_o), 64'd0);
    check("drain_ocup", 64'(ocup_o), 64'd0);
    check("drain_queue_left", 64'(exp_q.size()), 64'd0);
    ready_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [33:0] d;
    logic [1:0]  vcs [4];
    vcs[0] = 2'd1; vcs[1] = 2'd2; vcs[2] = 2'd3; vcs[3] = 2'd0;

    // Reset state
    do_reset(2);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ocup", 64'(ocup_o), 64'd0);
    check("rst_afull", 64'(almost_full_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_fdata", 64'(fdata_o), 64'd0);
    check("rst_vc", 64'(vc_id_o), 64'd0);

    // Fill with head + 3 bodies, no reads
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 34'h0_0000_0001 : (34'h1_0000_0001 + 34'(i));
      put(vcs[i], d, 1'b1);
      check("fill_ocup", 64'(ocup_o), 64'(i + 1));
      check("fill_afull", 64'(almost_full_o), 64'(i >= 2));
      check("fill_ready", 64'(ready_o), 64'(i < 3));
      check("fill_head_flit", 64'(fdata_o), 64'h0_0000_0001);
      check("fill_head_vc", 64'(vc_id_o), 64'd1);
    end

    // Full: valid and read together -> only the read happens
    vc_id_i = 2'd1;
    fdata_i = 34'h1_0000_0005;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("full_rw_ocup", 64'(ocup_o), 64'd3);
    check("full_rw_ready", 64'(ready_o), 64'd1);
    // Simultaneous read+write at occupancy 3 over pointer wrap, ending with a tail
    for (int k = 5; k <= 14; k++) begin
      d = (k == 14) ? {2'b10, 32'(k)} : {2'b01, 32'(k)};
      vc_id_i = 2'(k);
      fdata_i = d;
      exp_q.push_back({2'(k), d});
      @(posedge clk);
      #1;
      check("rw_ocup", 64'(ocup_o), 64'd3);
    end
    drain();

    // Tail while unlocked -> dropped, sticky error
    put(2'd0, 34'h2_0000_00AA, 1'b0);
    check("lock_tail_ocup", 64'(ocup_o), 64'd0);
    check("lock_tail_err", 64'(err_o), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("lock_err_sticky", 64'(err_o), 64'd1);

    // After reset: head, second head dropped, tail unlocks, single accepted
    do_reset(1);
    check("rst2_err", 64'(err_o), 64'd0);
    put(2'd2, 34'h0_0000_0010, 1'b1);
    check("lock_head_ocup", 64'(ocup_o), 64'd1);
    put(2'd2, 34'h0_0000_0011, 1'b0);
    check("lock_head2_ocup", 64'(ocup_o), 64'd1);
    check("lock_head2_err", 64'(err_o), 64'd1);
    put(2'd2, 34'h2_0000_0012, 1'b1);
    check("lock_tail_ocup2", 64'(ocup_o), 64'd2);
    put(2'd3, 34'h3_0000_0013, 1'b1);
    check("lock_single_ocup", 64'(ocup_o), 64'd3);
    check("lock_single_afull", 64'(almost_full_o), 64'd1);
    drain();

    // Back-to-back singles with continuous read: 1-cycle latency
    do_reset(1);
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 34'h3_0000_0100 + 34'(i);
      vc_id_i = 2'(i);
      fdata_i = d;
      valid_i = 1'b1;
      exp_q.push_back({2'(i), d});
      @(posedge clk);
      #1;
      check("single_latency_flit", 64'(fdata_o), 64'(d));
      check("single_ocup", 64'(ocup_o), 64'd1);
    end
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("single_empty", 64'(valid_o), 64'd0);
    check("single_err", 64'(err_o), 64'd0);
    check("single_queue_left", 64'(exp_q.size()), 64'd0);

    // Reset mid-packet with 2 flits queued
    ready_i = 1'b0;
    put(2'd1, 34'h0_0000_0020, 1'b1);
    put(2'd1, 34'h1_0000_0021, 1'b1);
    check("mid_ocup", 64'(ocup_o), 64'd2);
    do_reset(1);
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_ocup", 64'(ocup_o), 64'd0);
    put(2'd1, 34'h1_0000_0022, 1'b0);
    check("mid_body_ocup", 64'(ocup_o), 64'd0);
    check("mid_body_err", 64'(err_o), 64'd1);
    put(2'd1, 34'h0_0000_0023, 1'b1);
    check("mid_head_ocup", 64'(ocup_o), 64'd1);
    check("mid_head_flit", 64'(fdata_o), 64'h0_0000_0023);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
